// File: rtl/uart_byte_tx_if.sv
// Byte-request / serial-line bundle between the TRNG byte packer and the UART transmitter.
// Handshake: the packer may raise transmit for a cycle only while is_transmitting is 0; tx_byte is taken
// on the edge that sees transmit=1 in IDLE, and transmit seen while is_transmitting=1 is dropped.
interface uart_byte_tx_if;
  logic       transmit;
  logic [7:0] tx_byte;
  logic       tx;
  logic       is_transmitting;
  logic [1:0] dbg_state;

  modport master (
    output transmit,
    output tx_byte,
    input  tx,
    input  is_transmitting,
    input  dbg_state
  );

  modport slave (
    input  transmit,
    input  tx_byte,
    output tx,
    output is_transmitting,
    output dbg_state
  );
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1/8N2 serial transmitter: one frame per accepted byte, LSB first, line idles high.
// All outputs are registered; state is exported on dbg_state for observation.
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input logic          clk,
  input logic          rst,
  uart_byte_tx_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic            stop_cnt;
  logic [7:0]      shreg;
  logic            tx_r;
  logic            busy_r;
  logic            baud_end;

  assign baud_end = (baud_cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_r   <= 1'b1;
          busy_r <= 1'b0;
          if (bus.transmit) begin
            shreg    <= bus.tx_byte;
            tx_r     <= 1'b0;
            busy_r   <= 1'b1;
            baud_cnt <= '0;
            stop_cnt <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            tx_r     <= shreg[0];
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            shreg    <= shreg >> 1;
            if (bit_idx == 3'd7) begin
              tx_r     <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= STOP;
            end else begin
              // shreg[1] is the bit that becomes shreg[0] after this shift
              tx_r    <= shreg[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              busy_r <= 1'b0;
              state  <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        default: begin
          state  <= IDLE;
          tx_r   <= 1'b1;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx              = tx_r;
  assign bus.is_transmitting = busy_r;
  assign bus.dbg_state       = state;

endmodule
